rom_scan_ctrl: RTL and testbench

//   Sequencer for the image ROM: on a start pulse, walks rd_addr 0..PIXELS-1 in raster order,

---
 rtl/rom_scan_if.sv | 47 ++++
 rtl/rom_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rom_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_scan_if.sv
// ---------------------------------------------------------------------------
// rom_scan_if
//   Bundles the control, ROM-side and pixel-stream signals of rom_scan_ctrl.
//   The clock and reset stay outside the interface as plain ports.
//
//   start      frame request            (master -> slave)
//   abort      abort current frame      (master -> slave)
//   rd_addr    ROM read address         (slave  -> master)
//   read_data  ROM data for rd_addr     (master -> slave)
//   out_pixel  registered pixel         (slave  -> master)
//   out_valid  pixel/flags valid        (slave  -> master)
//   out_ready  downstream ready         (master -> slave)
//   out_sol    column 0 flag            (slave  -> master)
//   out_eol    last column flag         (slave  -> master)
//   out_eof    last pixel flag          (slave  -> master)
//   busy       frame in progress        (slave  -> master)
//   done       end-of-frame pulse       (slave  -> master)
//
//   master: the environment (ROM, requester, downstream sink)
//   slave : the sequencer itself
// ---------------------------------------------------------------------------
interface rom_scan_if #(
    parameter int BPP = 3
);
    logic               start;
    logic               abort;
    logic [9:0]         rd_addr;
    logic [8*BPP-1:0]   read_data;
    logic [8*BPP-1:0]   out_pixel;
    logic               out_valid;
    logic               out_ready;
    logic               out_sol;
    logic               out_eol;
    logic               out_eof;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, read_data, out_ready,
        input  rd_addr, out_pixel, out_valid, out_sol, out_eol, out_eof, busy, done
    );

    modport slave (
        input  start, abort, read_data, out_ready,
        output rd_addr, out_pixel, out_valid, out_sol, out_eol, out_eof, busy, done
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// ---------------------------------------------------------------------------
// rom_scan_ctrl
//   Streams one image frame out of a combinational-read ROM per start pulse.
//   Addresses are walked 0..PIXELS-1 in raster order; each ROM word is
//   captured into an output register and offered downstream on a
//   valid/ready handshake with start-of-line, end-of-line and end-of-frame
//   flags. A done pulse follows acceptance of the last pixel.
//
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of rom_scan_if (start, abort, rd_addr, read_data,
//          out_pixel, out_valid, out_ready, out_sol/eol/eof, busy, done)
//
//   HEIGHT*WIDTH must not exceed 1024 (10-bit ROM address).
// ---------------------------------------------------------------------------
module rom_scan_ctrl #(
    parameter int HEIGHT = 30,
    parameter int WIDTH  = 30,
    parameter int BPP    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_scan_if.slave     bus
);
    localparam int PIXELS = HEIGHT * WIDTH;
    localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW     = 8 * BPP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [9:0]      rd_addr_q,   rd_addr_d;
    logic [CW-1:0]   col_q,       col_d;
    logic [RW-1:0]   row_q,       row_d;
    logic [PW-1:0]   out_pixel_q, out_pixel_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sol_q,   out_sol_d;
    logic            out_eol_q,   out_eol_d;
    logic            out_eof_q,   out_eof_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;
    logic            load;

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        col_d       = col_q;
        row_d       = row_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = out_valid_q;
        out_sol_d   = out_sol_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;

        if (bus.abort) begin
            // Abort wins over start and load; a pixel on the bus this cycle
            // is dropped and no done pulse is produced.
            state_d     = IDLE;
            rd_addr_d   = '0;
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
            out_sol_d   = 1'b0;
            out_eol_d   = 1'b0;
            out_eof_d   = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d   = RUN;
                        rd_addr_d = '0;
                        col_d     = '0;
                        row_d     = '0;
                        busy_d    = 1'b1;
                    end
                end
                RUN: begin
                    // The output register may be refilled when empty or when
                    // its current pixel is being accepted this cycle.
                    load = !out_valid_q || bus.out_ready;
                    if (load) begin
                        out_pixel_d = bus.read_data;
                        out_valid_d = 1'b1;
                        out_sol_d   = (col_q == '0);
                        out_eol_d   = (col_q == CW'(WIDTH - 1));
                        out_eof_d   = (rd_addr_q == 10'(PIXELS - 1));
                        if (col_q == CW'(WIDTH - 1)) begin
                            col_d = '0;
                            row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        // The address stops at the last pixel so it never
                        // leaves the frame.
                        if (rd_addr_q == 10'(PIXELS - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            rd_addr_d = rd_addr_q + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_sol_d   = 1'b0;
                        out_eol_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            out_sol_q   <= out_sol_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sol   = out_sol_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_scan_ctrl
//   Self-checking bench for rom_scan_ctrl. A ROM array feeds read_data; the
//   expected stream is the ROM contents in index order with flags derived
//   from the pixel index (column = index mod WIDTH).
// ---------------------------------------------------------------------------
module tb_rom_scan_ctrl;
    localparam int H   = 30;
    localparam int W   = 30;
    localparam int BPP = 3;
    localparam int P   = H * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rom_scan_if #(.BPP(BPP)) bus ();

    rom_scan_ctrl #(.HEIGHT(H), .WIDTH(W), .BPP(BPP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8*BPP-1:0] rom [0:1023];
    assign bus.read_data = rom[bus.rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic fill_rom(input bit random_data);
        for (int i = 0; i < 1024; i++)
            rom[i] = random_data ? (8*BPP)'($urandom) : (8*BPP)'(i);
    endtask

    // Collects one frame. The caller drives start at a falling edge just
    // before calling. Iteration cyc is the falling edge after the cyc-th
    // rising edge following the start edge. Returns early (without
    // transferring) when pixel stop_at is presented.
    task automatic stream(input bit rand_ready, input bit spam, input int stop_at,
                          output int n_xfer, output int first_valid, output int last_cyc);
        int k, sols, eols;
        bit prev_stall, finished;
        logic [8*BPP-1:0] prev_pix;
        logic [2:0] prev_flags, exp_flags, flags;
        k = 0; sols = 0; eols = 0; prev_stall = 0; finished = 0;
        prev_pix = '0; prev_flags = '0;
        first_valid = -1; last_cyc = -1; n_xfer = 0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            flags = {bus.out_sol, bus.out_eol, bus.out_eof};
            if (cyc == 0) begin
                n_checks++;
                if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_accept: busy=%b valid=%b, need busy=1 valid=0", bus.busy, bus.out_valid);
                end
            end
            n_checks++;
            if (bus.done !== 1'b0 || bus.rd_addr > 10'(P - 1)) begin
                n_fail++;
                $display("FAIL mid_frame: done=%b rd_addr=%0d at pixel %0d, need done=0 rd_addr<%0d", bus.done, bus.rd_addr, k, P);
            end
            if (prev_stall) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pixel !== prev_pix || flags !== prev_flags) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b pix=%h flags=%b, need 1 %h %b", bus.out_valid, bus.out_pixel, flags, prev_pix, prev_flags);
                end
            end
            if (!rand_ready && k > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no_bubble: valid=%b at pixel %0d, need 1", bus.out_valid, k);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (k == stop_at) begin
                    n_xfer = k;
                    return;
                end
            end
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spam && $urandom_range(0, 7) == 0) bus.start = 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                exp_flags = {(k % W) == 0, (k % W) == W - 1, k == P - 1};
                n_checks++;
                if (bus.out_pixel !== rom[k] || flags !== exp_flags) begin
                    n_fail++;
                    $display("FAIL pixel[%0d]: pix=%h flags=%b, need %h %b", k, bus.out_pixel, flags, rom[k], exp_flags);
                end
                sols += int'(bus.out_sol);
                eols += int'(bus.out_eol);
                k++;
                last_cyc = cyc;
                if (k == P) finished = 1;
            end
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_pix   = bus.out_pixel;
            prev_flags = flags;
        end
        n_xfer = k;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d pixels, need %0d", k, P);
            bus.start = 1'b0;
            return;
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            {bus.out_sol, bus.out_eol, bus.out_eof} !== 3'b000) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b, need 1 0 0", bus.done, bus.out_valid, bus.busy);
        end
        n_checks++;
        if (sols != H || eols != H) begin
            n_fail++;
            $display("FAIL flag_count: sol=%0d eol=%0d, need %0d each", sols, eols, H);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            {bus.out_sol, bus.out_eol, bus.out_eof} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s: valid=%b busy=%b done=%b flags=%b, need all 0", name,
                     bus.out_valid, bus.busy, bus.done, {bus.out_sol, bus.out_eol, bus.out_eof});
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("reset_ctrl");
        n_checks++;
        if (bus.rd_addr !== 10'd0 || bus.out_pixel !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rd_addr=%0d pix=%h, need 0 0", bus.rd_addr, bus.out_pixel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_no_start");
    endtask

    task automatic test_full_frame();
        int n, fv, lc;
        fill_rom(0);
        @(negedge clk);
        bus.start = 1'b1;
        stream(0, 0, -1, n, fv, lc);
        n_checks++;
        if (n != P || fv != 1 || lc != P) begin
            n_fail++;
            $display("FAIL full_frame: pixels=%0d first=%0d last=%0d, need %0d 1 %0d", n, fv, lc, P, P);
        end
        @(negedge clk);
        check_idle("done_one_cycle");
    endtask

    task automatic test_back_to_back();
        int n1, n2, fv, lc;
        fill_rom(1);
        @(negedge clk);
        bus.start = 1'b1;
        stream(0, 0, -1, n1, fv, lc);
        // start lands in the done cycle and must be accepted
        bus.start = 1'b1;
        stream(0, 0, -1, n2, fv, lc);
        n_checks++;
        if (n1 != P || n2 != P || fv != 1) begin
            n_fail++;
            $display("FAIL back_to_back: frames=%0d,%0d first=%0d, need %0d,%0d 1", n1, n2, fv, P, P);
        end
        @(negedge clk);
        check_idle("b2b_end");
    endtask

    task automatic test_backpressure();
        int n, fv, lc;
        fill_rom(1);
        @(negedge clk);
        bus.start = 1'b1;
        stream(1, 0, -1, n, fv, lc);
        n_checks++;
        if (n != P) begin
            n_fail++;
            $display("FAIL backpressure: pixels=%0d, need %0d", n, P);
        end
    endtask

    task automatic test_start_ignored();
        int n, fv, lc, dones;
        fill_rom(1);
        @(negedge clk);
        bus.start = 1'b1;
        stream(1, 1, -1, n, fv, lc);
        dones = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        n_checks++;
        if (n != P || dones != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: pixels=%0d dones=%0d busy=%b, need %0d 1 0", n, dones, bus.busy, P);
        end
    endtask

    task automatic test_abort();
        int n, fv, lc;
        fill_rom(1);
        @(negedge clk);
        bus.start = 1'b1;
        stream(1, 0, 100, n, fv, lc);
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("abort_next");
        n_checks++;
        if (n != 100 || bus.rd_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL abort_state: stopped at %0d rd_addr=%0d, need 100 0", n, bus.rd_addr);
        end
        repeat (5) begin
            @(negedge clk);
            check_idle("abort_quiet");
        end
        bus.start = 1'b1;
        stream(0, 0, -1, n, fv, lc);
        n_checks++;
        if (n != P) begin
            n_fail++;
            $display("FAIL abort_restart: pixels=%0d, need %0d", n, P);
        end
    endtask

    task automatic test_reset_mid();
        int n, fv, lc;
        fill_rom(1);
        @(negedge clk);
        bus.start = 1'b1;
        stream(1, 0, 450, n, fv, lc);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        n_checks++;
        if (bus.rd_addr !== 10'd0 || bus.out_pixel !== '0) begin
            n_fail++;
            $display("FAIL async_reset_data: rd_addr=%0d pix=%h, need 0 0", bus.rd_addr, bus.out_pixel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_no_resume");
        bus.start = 1'b1;
        stream(1, 0, -1, n, fv, lc);
        n_checks++;
        if (n != P) begin
            n_fail++;
            $display("FAIL reset_restart: pixels=%0d, need %0d", n, P);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_rom(0);
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
